// File: rtl/paramtype_fifo.sv
// Type-parameterised first-word-fall-through valid/ready FIFO holding S items of type T.
// Optional high-water-mark output 'peak' is enabled by defining PARAMTYPE_FIFO_PEAK_EN.
module paramtype_fifo #(
  parameter int unsigned S  = 4,
  parameter type         T  = logic [7:0],
  localparam int unsigned CW = (S < 2) ? 1 : $clog2(S + 1),
  localparam int unsigned PW = (S < 2) ? 1 : $clog2(S)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  T              in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output T              out_data,
  output logic [CW-1:0] count
`ifdef PARAMTYPE_FIFO_PEAK_EN
  ,
  output logic [CW-1:0] peak
`endif
);

  T              mem [S];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  // Modulo-S pointer advance so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(S - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count != CW'(S));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop)  rd_ptr <= inc_ptr(rd_ptr);
      count <= count_nxt;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef PARAMTYPE_FIFO_PEAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (count_nxt > peak) begin
      peak <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_paramtype_fifo.sv
// Bench for paramtype_fifo: S=4/3/2 byte FIFOs and an S=1 16-bit FIFO checked against a queue model.
module tb_paramtype_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 [3];
  logic [7:0] id8 [3];
  logic       ir8 [3];
  logic       ov8 [3];
  logic       or8 [3];
  logic [7:0] od8 [3];
  logic [2:0] cnt8 [3];

  logic        iv16, ir16, ov16, or16;
  logic [15:0] id16, od16;
  logic        cnt16;
`ifdef PARAMTYPE_FIFO_PEAK_EN
  logic        pk16;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_f
    localparam int unsigned SG = (g == 0) ? 4 : (g == 1) ? 3 : 2;
    localparam int unsigned GW = $clog2(SG + 1);
    logic [GW-1:0] c;
`ifdef PARAMTYPE_FIFO_PEAK_EN
    logic [GW-1:0] p;
`endif
    paramtype_fifo #(.S(SG), .T(logic [7:0])) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv8[g]), .in_ready(ir8[g]), .in_data(id8[g]),
      .out_valid(ov8[g]), .out_ready(or8[g]), .out_data(od8[g]),
      .count(c)
`ifdef PARAMTYPE_FIFO_PEAK_EN
      , .peak(p)
`endif
    );
    assign cnt8[g] = 3'(c);
  end

  paramtype_fifo #(.S(1), .T(logic [15:0])) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_data(id16),
    .out_valid(ov16), .out_ready(or16), .out_data(od16),
    .count(cnt16)
`ifdef PARAMTYPE_FIFO_PEAK_EN
    , .peak(pk16)
`endif
  );

  int          n_total = 0;
  int          n_pass  = 0;
  int          sz [4] = '{4, 3, 2, 1};
  int          mcnt [4];
  int          mpeak = 0;
  logic [15:0] q [4][$];

  typedef struct {
    int   idx;
    logic v;
    int   d;
    logic r;
    int   exp_cnt;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic sample(input int idx, output int a_ov, output int a_ir,
                        output int a_cnt, output int a_od);
    if (idx < 3) begin
      a_ov = int'(ov8[idx]); a_ir = int'(ir8[idx]);
      a_cnt = int'(cnt8[idx]); a_od = int'(od8[idx]);
    end else begin
      a_ov = int'(ov16); a_ir = int'(ir16);
      a_cnt = int'(cnt16); a_od = int'(od16);
    end
  endtask

  task automatic chk_idle(input int idx, input string tag);
    int a_ov, a_ir, a_cnt, a_od;
    sample(idx, a_ov, a_ir, a_cnt, a_od);
    chk({tag, "_out_valid"}, a_ov, 0);
    chk({tag, "_in_ready"}, a_ir, 1);
    chk({tag, "_count"}, a_cnt, 0);
    chk({tag, "_out_data"}, a_od, 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mcnt[k] = 0;
      q[k].delete();
    end
    mpeak = 0;
  endtask

  // One clock of traffic on instance idx; outputs compared against the model before the edge.
  task automatic step(input int idx, input logic v, input int d, input logic r);
    int   a_ov, a_ir, a_cnt, a_od;
    logic push, pop;
    if (idx < 3) begin
      iv8[idx] = v; id8[idx] = 8'(d); or8[idx] = r;
    end else begin
      iv16 = v; id16 = 16'(d); or16 = r;
    end
    @(negedge clk);
    sample(idx, a_ov, a_ir, a_cnt, a_od);
    chk($sformatf("i%0d_out_valid", idx), a_ov, int'(mcnt[idx] != 0));
    chk($sformatf("i%0d_in_ready", idx), a_ir, int'(mcnt[idx] != sz[idx]));
    chk($sformatf("i%0d_count", idx), a_cnt, mcnt[idx]);
    chk($sformatf("i%0d_out_data", idx), a_od,
        (mcnt[idx] != 0) ? int'(q[idx][0]) : 0);
`ifdef PARAMTYPE_FIFO_PEAK_EN
    if (idx == 3) chk("i3_peak", int'(pk16), mpeak);
`endif
    push = v && (mcnt[idx] != sz[idx]);
    pop  = r && (mcnt[idx] != 0);
    if (pop) void'(q[idx].pop_front());
    if (push) q[idx].push_back((idx < 3) ? 16'(d & 'hFF) : 16'(d));
    mcnt[idx] = mcnt[idx] + int'(push) - int'(pop);
    if (mcnt[idx] > mpeak && idx == 3) mpeak = mcnt[idx];
    @(posedge clk);
    #1;
    if (idx < 3) begin
      iv8[idx] = 1'b0; or8[idx] = 1'b0;
    end else begin
      iv16 = 1'b0; or16 = 1'b0;
    end
  endtask

  vec_t tbl [$];

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv8[k] = 1'b0; id8[k] = '0; or8[k] = 1'b0;
    end
    iv16 = 1'b0; id16 = '0; or16 = 1'b0;
    model_reset();

    // Fill/drain on S=4, full push attempt, and pop-on-empty with a concurrent push.
    tbl = '{
      '{0, 1'b1, 'h11, 1'b0, 1}, '{0, 1'b1, 'h22, 1'b0, 2},
      '{0, 1'b1, 'h33, 1'b0, 3}, '{0, 1'b1, 'h44, 1'b0, 4},
      '{0, 1'b1, 'h99, 1'b0, 4},
      '{0, 1'b0, 'h00, 1'b1, 3}, '{0, 1'b0, 'h00, 1'b1, 2},
      '{0, 1'b0, 'h00, 1'b1, 1}, '{0, 1'b0, 'h00, 1'b1, 0},
      '{0, 1'b0, 'h00, 1'b1, 0},
      '{0, 1'b1, 'h5A, 1'b1, 1}, '{0, 1'b0, 'h00, 1'b1, 0}
    };

    #12;
    for (int k = 0; k < 4; k++) chk_idle(k, $sformatf("rst%0d", k));
`ifdef PARAMTYPE_FIFO_PEAK_EN
    chk("rst_peak", int'(pk16), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].idx, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_count", i), int'(cnt8[tbl[i].idx]), tbl[i].exp_cnt);
    end
    chk("s4_drained_valid", int'(ov8[0]), 0);
    chk("s4_drained_data", int'(od8[0]), 0);

    // S=3 streaming with concurrent push/pop across pointer wrap.
    for (int i = 1; i <= 10; i++) begin
      step(1, 1'b1, i, 1'b1);
      chk($sformatf("s3_stream_count%0d", i), int'(cnt8[1]), 1);
    end
    step(1, 1'b0, 0, 1'b1);
    chk("s3_drained", int'(cnt8[1]), 0);

    // S=2 full, then pop without push, then simultaneous push and pop.
    step(2, 1'b1, 'h0A, 1'b0);
    step(2, 1'b1, 'h0B, 1'b0);
    chk("s2_full_ready", int'(ir8[2]), 0);
    step(2, 1'b1, 'h0C, 1'b1);
    chk("s2_edge1_count", int'(cnt8[2]), 1);
    step(2, 1'b1, 'h0C, 1'b1);
    chk("s2_edge2_count", int'(cnt8[2]), 1);
    chk("s2_next_out", int'(od8[2]), 'h0C);
    step(2, 1'b0, 0, 1'b1);

    // S=1, 16-bit item: alternate push and pop.
    step(3, 1'b1, 'hBEEF, 1'b0);
    chk("s1_full_ready", int'(ir16), 0);
    step(3, 1'b0, 0, 1'b1);
    step(3, 1'b1, 'h4321, 1'b0);
    step(3, 1'b1, 'h0000, 1'b1);
    step(3, 1'b1, 'hBEEF, 1'b0);
    step(3, 1'b0, 0, 1'b1);
`ifdef PARAMTYPE_FIFO_PEAK_EN
    chk("s1_peak", int'(pk16), 1);
`endif

    // Asynchronous reset between edges with three items stored.
    step(0, 1'b1, 'hA1, 1'b0);
    step(0, 1'b1, 'hA2, 1'b0);
    step(0, 1'b1, 'hA3, 1'b0);
    chk("pre_rst_count", int'(cnt8[0]), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle(0, "async_rst");
`ifdef PARAMTYPE_FIFO_PEAK_EN
    chk("async_rst_peak", int'(pk16), 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1'b1, 'h77, 1'b0);
    chk("post_rst_data", int'(od8[0]), 'h77);
    step(0, 1'b0, 0, 1'b1);
    step(0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
